// File: rtl/matrix_pkg.sv
// Shared types and defaults for the LED-matrix frame path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_pkg;

  // Frame geometry shared with the buffer writer: 16x8 pixels x 3 colours.
  localparam int DEF_BYTES_PER_FRAME = 384;
  // Idle clocks after the last byte so the matrix controllers latch the frame.
  localparam int DEF_GAP_CYCLES      = 1000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT_RDY,
    S_START,
    S_WAIT_ACK,
    S_NEXT,
    S_DRAIN,
    S_GAP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Latency: loading N gives done_o in the (N+1)th cycle after the load edge.
// Backpressure: none; a load always wins over counting.
module cycle_timer #(
  parameter int MAX_COUNT = 1,
  parameter int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] count_q, count_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/matrix_frame_sequencer.sv
// Streams one frame from the frame buffer into nspi_tx, then holds a latch gap.
// Latency: mem_rd_en at +1, tx_data at +3, first tx_start at +3 after frame_start.
// Backpressure: waits on tx_finish before each start; aborts frame on ACK timeout.
module matrix_frame_sequencer
  import matrix_pkg::*;
#(
  parameter int CHANNEL_NUMBER  = 2,
  parameter int SPI_SIZE        = 8,
  parameter int BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT     = 64,
  parameter int ADDR_WIDTH      = $clog2(BYTES_PER_FRAME)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  output logic                               frame_busy,
  output logic                               frame_done,
  output logic                               tx_error,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] mem_rdata,
  output logic                               tx_start,
  input  logic                               tx_finish,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] tx_data
);

  localparam int DW    = CHANNEL_NUMBER * SPI_SIZE;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BYTES_PER_FRAME - 1);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [DW-1:0]         tx_data_q, tx_data_d;
  logic                  tx_error_q, tx_error_d;
  logic                  busy_q, done_q, rd_en_q, start_q;
  logic                  ack_load, ack_done;
  logic                  gap_load, gap_done;

  // The ACK window starts in the START cycle itself, so it is loaded one short
  // on the edge entering START; the gap is loaded on DRAIN exit and runs to zero.
  cycle_timer #(.MAX_COUNT(ACK_TIMEOUT)) u_ack_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ack_load),
    .load_val_i (ACK_W'(ACK_TIMEOUT - 1)),
    .done_o     (ack_done)
  );

  cycle_timer #(.MAX_COUNT(GAP_CYCLES)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_CYCLES)),
    .done_o     (gap_done)
  );

  // Next-state, index, data capture and error flag.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tx_data_d  = tx_data_q;
    tx_error_d = tx_error_q;
    gap_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          index_d    = '0;
          tx_error_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = mem_rdata;
        // Skip the ready wait entirely when the transmitter is already idle.
        state_d   = tx_finish ? S_START : S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (tx_finish) state_d = S_START;
      end
      S_START: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!tx_finish) begin
          state_d = S_NEXT;
        end else if (ack_done) begin
          tx_error_d = 1'b1;
          state_d    = S_DRAIN;
        end
      end
      S_NEXT: begin
        if (index_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          index_d = index_q + ADDR_WIDTH'(1);
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (tx_finish) begin
          gap_load = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ack_load = (state_d == S_START);

  // State and output registers; strobes are decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      tx_data_q  <= '0;
      tx_error_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      tx_data_q  <= tx_data_d;
      tx_error_q <= tx_error_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      rd_en_q    <= (state_d == S_FETCH);
      start_q    <= (state_d == S_START);
    end
  end

  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign tx_error   = tx_error_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = index_q;
  assign tx_start   = start_q;
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed bench for matrix_frame_sequencer with an nspi_tx stub and RAM model.
// Latency: n/a.
// Backpressure: stub holds tx_finish low for 18 cycles per transfer.
module tb_matrix_frame_sequencer;

  localparam int BPF = 4;
  localparam int GAP = 10;
  localparam int ACK = 8;
  localparam int AW  = 2;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          frame_busy, frame_done, tx_error, mem_rd_en, tx_start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] tx_data;
  logic          tx_finish;

  always #5 clk = ~clk;

  matrix_frame_sequencer #(
    .CHANNEL_NUMBER  (2),
    .SPI_SIZE        (8),
    .BYTES_PER_FRAME (BPF),
    .GAP_CYCLES      (GAP),
    .ACK_TIMEOUT     (ACK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .tx_error    (tx_error),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .tx_start    (tx_start),
    .tx_finish   (tx_finish),
    .tx_data     (tx_data)
  );

  // Stub state, RAM model and event monitor.
  int   cyc = 0;
  int   since = 0;
  int   n_start = 0;
  int   n_done = 0;
  int   last_start_cyc = 0;
  int   last_rise_cyc = 0;
  int   done_cyc = 0;
  int   nodrop_at = 0;
  logic prev_fin = 1'b1;
  logic [7:0] ram_a;

  assign ram_a     = 8'(mem_addr);
  assign tx_finish = !(since >= 2 && since <= 19);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_fin <= tx_finish;
    if (tx_finish && !prev_fin) last_rise_cyc <= cyc;
    if (frame_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (mem_rd_en) mem_rdata <= {~ram_a, ram_a};
    if (rst) begin
      since <= 0;
    end else if (tx_start) begin
      n_start        <= n_start + 1;
      last_start_cyc <= cyc;
      since          <= (n_start + 1 == nodrop_at) ? 0 : 1;
    end else if (since != 0) begin
      since <= (since == 19) ? 0 : since + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {frame_busy, frame_done, tx_error, mem_rd_en, mem_addr, tx_start, tx_data};
  endfunction

  function automatic logic [22:0] mk(input logic b, input logic d, input logic e,
                                     input logic r, input logic [1:0] a,
                                     input logic s, input logic [15:0] t);
    return {b, d, e, r, a, s, t};
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          k;
    logic        fs;
    logic [22:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  initial begin
    int  f0, g0, h0, p0, s0, d0, idx, err_cyc, busy_cnt;
    bit  ok, seen;

    // Offsets from the frame_start cycle: {busy,done,err,rd_en,addr,tx_start,tx_data}.
    tbl[0]  = '{0,   1'b1, mk(0, 0, 0, 0, 2'd0, 0, 16'h0000)};
    tbl[1]  = '{1,   1'b0, mk(1, 0, 0, 1, 2'd0, 0, 16'h0000)};
    tbl[2]  = '{2,   1'b0, mk(1, 0, 0, 0, 2'd0, 0, 16'h0000)};
    tbl[3]  = '{3,   1'b0, mk(1, 0, 0, 0, 2'd0, 1, 16'hFF00)};
    tbl[4]  = '{4,   1'b0, mk(1, 0, 0, 0, 2'd0, 0, 16'hFF00)};
    tbl[5]  = '{7,   1'b0, mk(1, 0, 0, 1, 2'd1, 0, 16'hFF00)};
    tbl[6]  = '{9,   1'b0, mk(1, 0, 0, 0, 2'd1, 0, 16'hFE01)};
    tbl[7]  = '{24,  1'b0, mk(1, 0, 0, 0, 2'd1, 1, 16'hFE01)};
    tbl[8]  = '{28,  1'b0, mk(1, 0, 0, 1, 2'd2, 0, 16'hFE01)};
    tbl[9]  = '{30,  1'b1, mk(1, 0, 0, 0, 2'd2, 0, 16'hFD02)};
    tbl[10] = '{31,  1'b0, mk(1, 0, 0, 0, 2'd2, 0, 16'hFD02)};
    tbl[11] = '{45,  1'b0, mk(1, 0, 0, 0, 2'd2, 1, 16'hFD02)};
    tbl[12] = '{49,  1'b0, mk(1, 0, 0, 1, 2'd3, 0, 16'hFD02)};
    tbl[13] = '{66,  1'b0, mk(1, 0, 0, 0, 2'd3, 1, 16'hFC03)};
    tbl[14] = '{97,  1'b0, mk(1, 0, 0, 0, 2'd3, 0, 16'hFC03)};
    tbl[15] = '{98,  1'b1, mk(1, 1, 0, 0, 2'd3, 0, 16'hFC03)};
    tbl[16] = '{99,  1'b0, mk(0, 0, 0, 0, 2'd3, 0, 16'hFC03)};
    tbl[17] = '{101, 1'b0, mk(0, 0, 0, 0, 2'd3, 0, 16'hFC03)};

    // Reset held for 5 cycles, then idle with no request.
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      busy_cnt += int'(frame_busy);
    end
    chk("idle_busy_cycles", busy_cnt, 0);
    chk("idle_outputs", 32'(outs()), 32'd0);

    // Full frame driven by the vector table, with ignored mid-frame and
    // done-cycle requests folded in.
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    f0 = cyc;
    s0 = n_start;
    d0 = n_done;
    idx = 0;
    for (int k = 0; k <= 101; k++) begin
      @(negedge clk);
      if (idx < NV && tbl[idx].k == k) begin
        chk($sformatf("vec_k%0d", k), 32'(outs()), 32'(tbl[idx].exp));
        frame_start = tbl[idx].fs;
        idx++;
      end
    end
    chk("f1_tx_starts", n_start - s0, 4);
    chk("f1_done_count", n_done - d0, 1);
    chk("f1_done_after_rise", done_cyc - last_rise_cyc, 12);
    chk("f1_done_offset", done_cyc - f0, 98);

    // ACK timeout: the stub ignores the second start of this frame.
    nodrop_at = n_start + 2;
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    g0 = cyc;
    s0 = n_start;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    seen = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_error) begin
        seen = 1'b1;
        err_cyc = cyc;
        break;
      end
    end
    chk("to_err_seen", 32'(seen), 32'd1);
    chk("to_err_delay", err_cyc - last_start_cyc, 8);
    chk("to_err_offset", err_cyc - g0, 32);
    chk("to_starts_at_err", n_start - s0, 2);
    wait_done(200, ok);
    chk("to_done_seen", 32'(ok), 32'd1);
    chk("to_err_sticky", 32'(tx_error), 32'd1);
    chk("to_starts_total", n_start - s0, 2);
    chk("to_done_after_err", cyc - err_cyc, 12);
    nodrop_at = 0;

    // Back-to-back: request on the cycle right after frame_done.
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    h0 = cyc;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("b2b_rd_en", 32'(mem_rd_en), 32'd1);
    chk("b2b_addr", 32'(mem_addr), 32'd0);
    chk("b2b_err_cleared", 32'(tx_error), 32'd0);
    chk("b2b_offset", cyc - h0, 1);

    // Reset for one cycle while waiting for the first byte's acknowledge.
    repeat (3) @(negedge clk);
    chk("pre_rst_state", 32'(outs()), 32'(mk(1, 0, 0, 0, 2'd0, 0, 16'hFF00)));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_all_zero", 32'(outs()), 32'd0);
    rst = 1'b0;
    d0 = n_done;
    repeat (40) @(negedge clk);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_stays_idle", 32'(outs()), 32'd0);

    // Fresh frame after the abort restarts at address 0 and completes cleanly.
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    p0 = cyc;
    s0 = n_start;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("rst_restart_rd_en", 32'(mem_rd_en), 32'd1);
    chk("rst_restart_addr", 32'(mem_addr), 32'd0);
    wait_done(300, ok);
    chk("f4_done_seen", 32'(ok), 32'd1);
    chk("f4_tx_starts", n_start - s0, 4);
    chk("f4_done_after_rise", cyc - last_rise_cyc, 12);
    chk("f4_done_offset", cyc - p0, 98);
    chk("f4_tx_error", 32'(tx_error), 32'd0);
    chk("f4_last_data", 32'(tx_data), 32'h0000FC03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
